mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage.
- Consumes the EX/ME pipeline register outputs: ALU result, store data, rd, MEM_WE, WE, MEM_TO_REG.
- Performs word loads and stores over a req/ack data-memory port with variable latency, and stalls upstream while an access is outstanding.
- Drives the ME bypass value and the registered ME/WB pipeline outputs.

Parameters:
- XLEN, 32, data/address width (matches REG_SIZE).
- RNUM_W, 5, register-number width (matches REG_NUM_SIZE).
- TIMEOUT, 16, maximum WAIT cycles before a bus error is declared.
- CNT_W, 5, timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- ALU_OUT_ME  in  XLEN  ALU result; this is the address for memory ops.
- WD_ME  in  XLEN  store data.
- RD_ME  in  RNUM_W  destination register.
- MEM_WE_ME  in  1  store.
- WE_ME  in  1  register write enable.
- MEM_TO_REG_ME  in  1  load.
- DMEM_RDATA  in  XLEN  read data.
- DMEM_ACK  in  1  memory completion, one-cycle pulse.
- DMEM_REQ  out  1  request.
- DMEM_WE  out  1  write strobe, valid with REQ.
- DMEM_ADDR  out  XLEN  word-aligned address.
- DMEM_WDATA  out  XLEN  write data.
- STALL_ME  out  1  freeze PC/IF/DE/EX/ME registers.
- BP_MEM  out  XLEN  bypass value to execute.
- WB_DATA  out  XLEN  registered result to writeback.
- RD_WB  out  RNUM_W  registered rd.
- WE_WB  out  1  registered write enable.
- MISALIGN  out  1  sticky: access with addr[1:0] != 0.
- BUS_ERR  out  1  sticky: timeout.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counter=0. DMEM_REQ, WB_DATA, RD_WB, WE_WB, MISALIGN and BUS_ERR all go to 0 immediately. Any in-flight access is abandoned; a late ACK arriving in IDLE is ignored.
- mem_op = MEM_WE_ME | MEM_TO_REG_ME. If both are set, the op is treated as a store.
- BP_MEM = ALU_OUT_ME, combinational. The hazard unit handles load-use; BP_MEM is never load data.
- FSM states: IDLE, WAIT, DONE.
- IDLE, mem_op=0: no stall. At the clock edge, WB_DATA<=ALU_OUT_ME, RD_WB<=RD_ME, WE_WB<=WE_ME. Latency is one cycle.
- IDLE, mem_op=1, addr[1:0]!=0: MISALIGN<=1. No request is issued. The op completes like a non-mem op with WE_WB<=0. No stall.
- IDLE, mem_op=1, aligned:
  - STALL_ME=1.
  - Latch addr, wdata and the we flag internally.
  - WE_WB<=0 (bubble).
  - Counter<=0; go to WAIT.
- WAIT:
  - DMEM_REQ=1, driven from the latches, stable until ACK. STALL_ME=1.
  - Each cycle without ACK: counter+1.
  - ACK=1: capture DMEM_RDATA and go to DONE. ACK has priority over timeout in the same cycle.
  - Counter==TIMEOUT-1 without ACK: BUS_ERR<=1, captured data=0, mark error, go to DONE.
- DONE:
  - DMEM_REQ=0, STALL_ME=0; the instruction is still presented at the inputs.
  - At the edge: WB_DATA<=load ? captured : ALU_OUT_ME; RD_WB<=RD_ME; WE_WB<=WE_ME & ~error.
  - Go to IDLE.
- STALL_ME = (IDLE & mem_op & aligned) | WAIT, combinational.
- Minimum memory op: 3 cycles (ACK on the first WAIT cycle) with 2 stall cycles.
- WB outputs are written in IDLE (non-mem op), IDLE (misaligned op, WE_WB<=0), DONE and on stall-entry (WE_WB<=0 bubble). They hold in WAIT.
- Sticky flags clear only on reset.
- A store does not write the register file unless WE_ME=1; stores normally have WE_ME=0.

Decomposition:
- Shared constants header, alongside REG_SIZE, REG_NUM_SIZE and the zero constants: FSM state encodings ME_IDLE/ME_WAIT/ME_DONE (2 bits), and default TIMEOUT.
- One natural sub-module, dmem_req_ctrl: the FSM, latches and timeout counter, exposing done/rdata/err.
- The ME/WB register and bypass logic stay in mem_stage.

Test Plan:
- ALU op: ALU_OUT_ME=0x0000_0010, RD=3, WE=1, no mem → one cycle later WB_DATA=0x10, RD_WB=3, WE_WB=1; STALL_ME never high; BP_MEM=0x10 the same cycle.
- Load: addr 0x100, ACK on the first WAIT cycle with RDATA 0xDEAD_BEEF → STALL_ME high 2 cycles; REQ=1, WE=0, ADDR=0x100 during WAIT; WB_DATA=0xDEADBEEF, WE_WB=1 after DONE.
- Store: addr 0x104, WD=0x1234_5678, ACK after 5 wait cycles → REQ held 5 cycles with ADDR/WDATA stable, DMEM_WE=1; WE_WB=0 throughout.
- Timeout: load with no ACK, TIMEOUT=16 → after 16 WAIT cycles BUS_ERR=1, WE_WB stays 0, stall drops in DONE; an ACK on the final WAIT cycle instead completes normally.
- Misaligned: load addr 0x102 → MISALIGN=1, no REQ, no stall, WE_WB=0.
- Reset mid-WAIT: drop rst low → REQ/STALL_ME go to 0 immediately; after release, a late ACK is ignored and the next ALU op passes in one cycle.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared widths, zero constants and memory-stage FSM encodings
// Contents:
//   REG_SIZE / REG_NUM_SIZE   data and register-number widths
//   ZERO_REG / ZERO_RNUM      all-zero constants of those widths
//   ME_TIMEOUT_DEFAULT        default WAIT-cycle budget before a bus error
//   me_state_e                ME_IDLE / ME_WAIT / ME_DONE
package mem_stage_pkg;

  localparam int REG_SIZE           = 32;
  localparam int REG_NUM_SIZE       = 5;
  localparam int ME_TIMEOUT_DEFAULT = 16;

  localparam logic [REG_SIZE-1:0]     ZERO_REG  = '0;
  localparam logic [REG_NUM_SIZE-1:0] ZERO_RNUM = '0;

  typedef enum logic [1:0] {
    ME_IDLE = 2'd0,
    ME_WAIT = 2'd1,
    ME_DONE = 2'd2
  } me_state_e;

endpackage

// File: rtl/mem_stage_dmem_req_ctrl.sv
// rtl/mem_stage_dmem_req_ctrl.sv - data-memory request FSM with latches and timeout counter
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   start_i                aligned memory op presented while idle
//   store_i                op is a store (wins when load and store are both set)
//   addr_i, wdata_i        address / store data to latch on start
//   ack_i, rdata_i         memory completion pulse and read data
//   req_o, we_o            request and write strobe, driven from the latches
//   addr_o, wdata_o        latched address / write data
//   idle_o, wait_o, done_o current FSM state decodes
//   is_load_o              latched op was a load
//   rdata_o, err_o         captured data and timeout mark for the DONE cycle
//   timeout_o              one-cycle pulse on the cycle the budget expires
module dmem_req_ctrl
  import mem_stage_pkg::*;
#(
  parameter int XLEN    = REG_SIZE,
  parameter int TIMEOUT = ME_TIMEOUT_DEFAULT,
  parameter int CNT_W   = 5
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            store_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic            ack_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic            req_o,
  output logic            we_o,
  output logic [XLEN-1:0] addr_o,
  output logic [XLEN-1:0] wdata_o,
  output logic            idle_o,
  output logic            wait_o,
  output logic            done_o,
  output logic            is_load_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            err_o,
  output logic            timeout_o
);

  me_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            we_q, we_d;
  logic            err_q, err_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ME_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    we_d      = we_q;
    err_d     = err_q;
    timeout_o = 1'b0;
    unique case (state_q)
      ME_IDLE: begin
        // A late ACK arriving here is simply not looked at.
        if (start_i) begin
          addr_d  = addr_i;
          wdata_d = wdata_i;
          we_d    = store_i;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = ME_WAIT;
        end
      end
      ME_WAIT: begin
        // ACK wins over an expiring budget in the same cycle.
        if (ack_i) begin
          rdata_d = rdata_i;
          state_d = ME_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rdata_d   = '0;
          err_d     = 1'b1;
          timeout_o = 1'b1;
          state_d   = ME_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ME_DONE: state_d = ME_IDLE;
      default: state_d = ME_IDLE;
    endcase
  end

  assign idle_o    = (state_q == ME_IDLE);
  assign wait_o    = (state_q == ME_WAIT);
  assign done_o    = (state_q == ME_DONE);
  assign req_o     = wait_o;
  assign we_o      = we_q;
  assign addr_o    = addr_q;
  assign wdata_o   = wdata_q;
  assign is_load_o = ~we_q;
  assign rdata_o   = rdata_q;
  assign err_o     = err_q;

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access stage: dmem req/ack access, stall, bypass and ME/WB register
// Ports:
//   clk, rst                                   clock, asynchronous active-low reset
//   ALU_OUT_ME, WD_ME, RD_ME                   address/ALU result, store data, rd
//   MEM_WE_ME, WE_ME, MEM_TO_REG_ME            store, register write, load
//   DMEM_RDATA, DMEM_ACK                       memory read data and completion pulse
//   DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_WDATA   memory request side
//   STALL_ME                                   freeze upstream registers
//   BP_MEM                                     bypass value to execute
//   WB_DATA, RD_WB, WE_WB                      registered ME/WB outputs
//   MISALIGN, BUS_ERR                          sticky error flags
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN    = REG_SIZE,
  parameter int RNUM_W  = REG_NUM_SIZE,
  parameter int TIMEOUT = ME_TIMEOUT_DEFAULT,
  parameter int CNT_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   ALU_OUT_ME,
  input  logic [XLEN-1:0]   WD_ME,
  input  logic [RNUM_W-1:0] RD_ME,
  input  logic              MEM_WE_ME,
  input  logic              WE_ME,
  input  logic              MEM_TO_REG_ME,
  input  logic [XLEN-1:0]   DMEM_RDATA,
  input  logic              DMEM_ACK,
  output logic              DMEM_REQ,
  output logic              DMEM_WE,
  output logic [XLEN-1:0]   DMEM_ADDR,
  output logic [XLEN-1:0]   DMEM_WDATA,
  output logic              STALL_ME,
  output logic [XLEN-1:0]   BP_MEM,
  output logic [XLEN-1:0]   WB_DATA,
  output logic [RNUM_W-1:0] RD_WB,
  output logic              WE_WB,
  output logic              MISALIGN,
  output logic              BUS_ERR
);

  logic            mem_op, aligned, start;
  logic            idle, waiting, done, is_load, err, timeout;
  logic [XLEN-1:0] cap_rdata;

  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic [RNUM_W-1:0] rd_wb_q, rd_wb_d;
  logic              we_wb_q, we_wb_d;
  logic              misalign_q, misalign_d;
  logic              bus_err_q, bus_err_d;

  assign mem_op  = MEM_WE_ME | MEM_TO_REG_ME;
  assign aligned = (ALU_OUT_ME[1:0] == 2'b00);
  assign start   = idle & mem_op & aligned;

  dmem_req_ctrl #(
    .XLEN    (XLEN),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_ctrl (
    .clk_i     (clk),
    .rst_ni    (rst),
    .start_i   (start),
    .store_i   (MEM_WE_ME),
    .addr_i    (ALU_OUT_ME),
    .wdata_i   (WD_ME),
    .ack_i     (DMEM_ACK),
    .rdata_i   (DMEM_RDATA),
    .req_o     (DMEM_REQ),
    .we_o      (DMEM_WE),
    .addr_o    (DMEM_ADDR),
    .wdata_o   (DMEM_WDATA),
    .idle_o    (idle),
    .wait_o    (waiting),
    .done_o    (done),
    .is_load_o (is_load),
    .rdata_o   (cap_rdata),
    .err_o     (err),
    .timeout_o (timeout)
  );

  // Gated by reset so the stall drops the instant reset asserts, even while
  // the upstream still presents an aligned memory op.
  assign STALL_ME = rst & (start | waiting);
  assign BP_MEM   = ALU_OUT_ME;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_data_q  <= '0;
      rd_wb_q    <= '0;
      we_wb_q    <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      wb_data_q  <= wb_data_d;
      rd_wb_q    <= rd_wb_d;
      we_wb_q    <= we_wb_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  always_comb begin
    wb_data_d  = wb_data_q;
    rd_wb_d    = rd_wb_q;
    we_wb_d    = we_wb_q;
    misalign_d = misalign_q;
    bus_err_d  = bus_err_q | timeout;
    if (idle) begin
      if (!mem_op) begin
        wb_data_d = ALU_OUT_ME;
        rd_wb_d   = RD_ME;
        we_wb_d   = WE_ME;
      end else if (!aligned) begin
        // Misaligned op retires without touching memory or the register file.
        wb_data_d  = ALU_OUT_ME;
        rd_wb_d    = RD_ME;
        we_wb_d    = 1'b0;
        misalign_d = 1'b1;
      end else begin
        we_wb_d = 1'b0;
      end
    end else if (done) begin
      // The instruction is still held at the inputs by the stall.
      wb_data_d = is_load ? cap_rdata : ALU_OUT_ME;
      rd_wb_d   = RD_ME;
      we_wb_d   = WE_ME & ~err;
    end
  end

  assign WB_DATA  = wb_data_q;
  assign RD_WB    = rd_wb_q;
  assign WE_WB    = we_wb_q;
  assign MISALIGN = misalign_q;
  assign BUS_ERR  = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed scoreboard bench for mem_stage
module tb_mem_stage;

  localparam int XLEN    = 32;
  localparam int RNUM_W  = 5;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [XLEN-1:0]   alu_out, wd, dmem_rdata;
  logic [RNUM_W-1:0] rd;
  logic              mem_we, we, mem_to_reg, dmem_ack;
  logic              dmem_req, dmem_we, stall, we_wb, misalign, bus_err;
  logic [XLEN-1:0]   dmem_addr, dmem_wdata, bp_mem, wb_data;
  logic [RNUM_W-1:0] rd_wb;

  typedef struct packed {
    logic [XLEN-1:0]   data;
    logic [RNUM_W-1:0] rd;
    logic              we;
  } wb_t;

  wb_t sb[$];
  int  n_checks = 0;
  int  n_errors = 0;

  mem_stage #(.XLEN(XLEN), .RNUM_W(RNUM_W), .TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .ALU_OUT_ME    (alu_out),
    .WD_ME         (wd),
    .RD_ME         (rd),
    .MEM_WE_ME     (mem_we),
    .WE_ME         (we),
    .MEM_TO_REG_ME (mem_to_reg),
    .DMEM_RDATA    (dmem_rdata),
    .DMEM_ACK      (dmem_ack),
    .DMEM_REQ      (dmem_req),
    .DMEM_WE       (dmem_we),
    .DMEM_ADDR     (dmem_addr),
    .DMEM_WDATA    (dmem_wdata),
    .STALL_ME      (stall),
    .BP_MEM        (bp_mem),
    .WB_DATA       (wb_data),
    .RD_WB         (rd_wb),
    .WE_WB         (we_wb),
    .MISALIGN      (misalign),
    .BUS_ERR       (bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [XLEN-1:0] a, input logic [XLEN-1:0] d, input logic [RNUM_W-1:0] r,
                       input logic mwe, input logic w, input logic m2r);
    alu_out = a; wd = d; rd = r; mem_we = mwe; we = w; mem_to_reg = m2r;
  endtask

  task automatic nop();
    drive('0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop_check(input string tag);
    wb_t e;
    chk({tag, "_sb_depth"}, XLEN'(sb.size()), XLEN'(1));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_wb_data"}, wb_data, e.data);
      chk({tag, "_rd_wb"}, XLEN'(rd_wb), XLEN'(e.rd));
      chk({tag, "_we_wb"}, XLEN'(we_wb), XLEN'(e.we));
    end
  endtask

  // ack_at: WAIT-cycle index (0-based) on which ACK is given; -1 means never.
  task automatic mem_access(input string tag, input logic [XLEN-1:0] addr, input logic [XLEN-1:0] data,
                            input logic [RNUM_W-1:0] r, input logic store, input logic w,
                            input int ack_at, input logic [XLEN-1:0] rdata,
                            input logic [XLEN-1:0] exp_data, input logic exp_we);
    int n_wait;
    wb_t e;
    n_wait = (ack_at >= 0) ? ack_at + 1 : TIMEOUT;
    @(negedge clk);
    drive(addr, data, r, store, w, ~store);
    e.data = exp_data; e.rd = r; e.we = exp_we;
    sb.push_back(e);
    #1;
    chk({tag, "_entry_stall"}, XLEN'(stall), XLEN'(1));
    chk({tag, "_entry_req"}, XLEN'(dmem_req), XLEN'(0));
    chk({tag, "_bp_mem"}, bp_mem, addr);
    for (int i = 0; i < n_wait; i++) begin
      @(negedge clk);
      chk({tag, "_wait_req"}, XLEN'(dmem_req), XLEN'(1));
      chk({tag, "_wait_stall"}, XLEN'(stall), XLEN'(1));
      chk({tag, "_wait_addr"}, dmem_addr, addr);
      chk({tag, "_wait_we"}, XLEN'(dmem_we), XLEN'(store));
      if (store) chk({tag, "_wait_wdata"}, dmem_wdata, data);
      chk({tag, "_wait_we_wb"}, XLEN'(we_wb), XLEN'(0));
      if (i == ack_at) begin
        dmem_ack = 1'b1;
        dmem_rdata = rdata;
      end
      @(posedge clk);
      #1;
      dmem_ack = 1'b0;
    end
    @(negedge clk);
    chk({tag, "_done_req"}, XLEN'(dmem_req), XLEN'(0));
    chk({tag, "_done_stall"}, XLEN'(stall), XLEN'(0));
    chk({tag, "_done_we_wb"}, XLEN'(we_wb), XLEN'(0));
    @(posedge clk);
    #1;
    pop_check(tag);
    nop();
  endtask

  initial begin
    wb_t e;
    rst = 1'b0;
    nop();
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    #2;
    chk("rst_req", XLEN'(dmem_req), XLEN'(0));
    chk("rst_stall", XLEN'(stall), XLEN'(0));
    chk("rst_wb_data", wb_data, '0);
    chk("rst_rd_wb", XLEN'(rd_wb), XLEN'(0));
    chk("rst_we_wb", XLEN'(we_wb), XLEN'(0));
    chk("rst_misalign", XLEN'(misalign), XLEN'(0));
    chk("rst_bus_err", XLEN'(bus_err), XLEN'(0));
    @(negedge clk);
    rst = 1'b1;

    // Plain ALU op: one-cycle latency, no stall.
    @(negedge clk);
    drive(32'h0000_0010, '0, 5'd3, 1'b0, 1'b1, 1'b0);
    e.data = 32'h10; e.rd = 5'd3; e.we = 1'b1;
    sb.push_back(e);
    #1;
    chk("alu_stall", XLEN'(stall), XLEN'(0));
    chk("alu_bp_mem", bp_mem, 32'h10);
    chk("alu_req", XLEN'(dmem_req), XLEN'(0));
    @(posedge clk);
    #1;
    pop_check("alu");
    chk("alu_stall_after", XLEN'(stall), XLEN'(0));
    nop();

    mem_access("load", 32'h100, '0, 5'd5, 1'b0, 1'b1, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
    mem_access("store", 32'h104, 32'h1234_5678, 5'd7, 1'b1, 1'b0, 4, 32'hFFFF_FFFF, 32'h104, 1'b0);
    chk("pre_timeout_bus_err", XLEN'(bus_err), XLEN'(0));
    mem_access("timeout", 32'h200, '0, 5'd9, 1'b0, 1'b1, -1, '0, '0, 1'b0);
    chk("timeout_bus_err", XLEN'(bus_err), XLEN'(1));
    mem_access("ack_last", 32'h204, '0, 5'd10, 1'b0, 1'b1, TIMEOUT - 1, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1);
    chk("ack_last_bus_err_sticky", XLEN'(bus_err), XLEN'(1));

    // Misaligned load: flagged, no request, no stall, no register write.
    chk("pre_misalign", XLEN'(misalign), XLEN'(0));
    @(negedge clk);
    drive(32'h102, '0, 5'd11, 1'b0, 1'b1, 1'b1);
    e.data = 32'h102; e.rd = 5'd11; e.we = 1'b0;
    sb.push_back(e);
    #1;
    chk("mis_stall", XLEN'(stall), XLEN'(0));
    chk("mis_req", XLEN'(dmem_req), XLEN'(0));
    @(posedge clk);
    #1;
    pop_check("mis");
    chk("mis_flag", XLEN'(misalign), XLEN'(1));
    chk("mis_req_after", XLEN'(dmem_req), XLEN'(0));
    nop();

    // Reset in the middle of a WAIT.
    @(negedge clk);
    drive(32'h300, '0, 5'd12, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rstw_req_before", XLEN'(dmem_req), XLEN'(1));
    #2;
    rst = 1'b0;
    #1;
    chk("rstw_req", XLEN'(dmem_req), XLEN'(0));
    chk("rstw_stall", XLEN'(stall), XLEN'(0));
    chk("rstw_we_wb", XLEN'(we_wb), XLEN'(0));
    chk("rstw_misalign", XLEN'(misalign), XLEN'(0));
    chk("rstw_bus_err", XLEN'(bus_err), XLEN'(0));
    nop();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b1;
    dmem_rdata = 32'h5A5A_5A5A;
    @(posedge clk);
    #1;
    dmem_ack = 1'b0;
    chk("late_ack_req", XLEN'(dmem_req), XLEN'(0));
    chk("late_ack_stall", XLEN'(stall), XLEN'(0));
    chk("late_ack_we_wb", XLEN'(we_wb), XLEN'(0));
    @(negedge clk);
    drive(32'h55, '0, 5'd13, 1'b0, 1'b1, 1'b0);
    e.data = 32'h55; e.rd = 5'd13; e.we = 1'b1;
    sb.push_back(e);
    #1;
    chk("post_rst_stall", XLEN'(stall), XLEN'(0));
    @(posedge clk);
    #1;
    pop_check("post_rst_alu");
    nop();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
